// File: rtl/hwpe_ctrl_seq_fsm.sv
// HWPE tile sequencer: load -> compute -> store per tile, then micro-loop advance, until done or tile cap.
// Optional per-wait-state watchdog is compiled in when HWPE_CTRL_SEQ_TIMEOUT_EN is defined.
module hwpe_ctrl_seq_fsm #(
  parameter int unsigned CNT_WIDTH      = 12,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic [CNT_WIDTH-1:0] cfg_n_tiles_i,
  output logic                 uloop_clear_o,
  output logic                 uloop_enable_o,
  input  logic                 uloop_valid_i,
  input  logic                 uloop_done_i,
  output logic                 stream_start_o,
  input  logic                 stream_done_i,
  output logic                 engine_start_o,
  input  logic                 engine_done_i,
  output logic                 store_start_o,
  input  logic                 store_done_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CNT_WIDTH-1:0] tile_cnt_o,
  output logic                 err_o
);

  // state    | meaning
  // IDLE     | waiting for start_i
  // LOAD     | load stream running
  // COMPUTE  | engine running
  // STORE    | store stream running
  // UPDATE   | tile count bumped; advancing micro-loop unless the cap is hit
  // FINISHED | one-cycle done_o, then IDLE
  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, STORE, UPDATE, FINISHED} state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cap_q, cap_d, tile_cnt_d;
  logic                 uloop_clear_d, uloop_enable_d, stream_start_d, engine_start_d;
  logic                 store_start_d, busy_d, done_d;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("TIMEOUT_CYCLES must be nonzero");
  end

`ifdef HWPE_CTRL_SEQ_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q;
  logic            err_q, err_d;
`endif

  always_comb begin
    state_d    = state_q;
    cap_d      = cap_q;
    tile_cnt_d = tile_cnt_o;
    uloop_clear_d = 1'b0;
`ifdef HWPE_CTRL_SEQ_TIMEOUT_EN
    err_d = err_q;
`endif
    // A done arriving in the start-pulse cycle belongs to no request yet, so it is dropped.
    case (state_q)
      IDLE: if (start_i) begin
        state_d       = LOAD;
        cap_d         = cfg_n_tiles_i;
        tile_cnt_d    = '0;
        uloop_clear_d = 1'b1;
`ifdef HWPE_CTRL_SEQ_TIMEOUT_EN
        err_d         = 1'b0;
`endif
      end
      LOAD:    if (stream_done_i && !stream_start_o) state_d = COMPUTE;
      COMPUTE: if (engine_done_i && !engine_start_o) state_d = STORE;
      STORE: if (store_done_i && !store_start_o) begin
        state_d    = UPDATE;
        tile_cnt_d = tile_cnt_o + 1'b1;
      end
      UPDATE: begin
        if (cap_q != '0 && tile_cnt_o == cap_q) state_d = FINISHED;
        else if (uloop_valid_i) state_d = uloop_done_i ? FINISHED : LOAD;
      end
      FINISHED: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
`ifdef HWPE_CTRL_SEQ_TIMEOUT_EN
    if (wd_q == '0 && state_d == state_q &&
        state_q inside {LOAD, COMPUTE, STORE, UPDATE}) begin
      state_d = FINISHED;
      err_d   = 1'b1;
    end
    if (clear_i) err_d = 1'b0;
`endif
    if (clear_i) begin
      state_d       = IDLE;
      tile_cnt_d    = '0;
      uloop_clear_d = 1'b0;
    end
    stream_start_d = (state_d == LOAD)    && (state_q != LOAD);
    engine_start_d = (state_d == COMPUTE) && (state_q != COMPUTE);
    store_start_d  = (state_d == STORE)   && (state_q != STORE);
    uloop_enable_d = (state_d == UPDATE) && !(cap_d != '0 && tile_cnt_d == cap_d);
    busy_d         = (state_d != IDLE);
    done_d         = (state_d == FINISHED);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      cap_q          <= '0;
      tile_cnt_o     <= '0;
      uloop_clear_o  <= 1'b0;
      uloop_enable_o <= 1'b0;
      stream_start_o <= 1'b0;
      engine_start_o <= 1'b0;
      store_start_o  <= 1'b0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cap_q          <= cap_d;
      tile_cnt_o     <= tile_cnt_d;
      uloop_clear_o  <= uloop_clear_d;
      uloop_enable_o <= uloop_enable_d;
      stream_start_o <= stream_start_d;
      engine_start_o <= engine_start_d;
      store_start_o  <= store_start_d;
      busy_o         <= busy_d;
      done_o         <= done_d;
    end
  end

`ifdef HWPE_CTRL_SEQ_TIMEOUT_EN
  // Down-counter reloaded on every state change; terminal count zero fires the watchdog.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
      if (clear_i || state_d != state_q) wd_q <= WD_W'(TIMEOUT_CYCLES - 1);
      else if (wd_q != '0)               wd_q <= wd_q - 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_hwpe_ctrl_seq_fsm.sv
// Bench for hwpe_ctrl_seq_fsm: job table plus hand sequences, done_o checked against a scoreboard queue.
module tb_hwpe_ctrl_seq_fsm;
  localparam int CW = 12;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n, clear_i, start_i;
  logic [CW-1:0] cfg_n_tiles_i;
  logic          uloop_clear_o, uloop_enable_o, uloop_valid_i, uloop_done_i;
  logic          stream_start_o, stream_done_i, engine_start_o, engine_done_i;
  logic          store_start_o, store_done_i, busy_o, done_o, err_o;
  logic [CW-1:0] tile_cnt_o;
  logic          engine_done_r, engine_done_m;

  assign engine_done_i = engine_done_r | engine_done_m;

  always #5 clk = ~clk;

  hwpe_ctrl_seq_fsm #(.CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear_i), .start_i(start_i),
    .cfg_n_tiles_i(cfg_n_tiles_i),
    .uloop_clear_o(uloop_clear_o), .uloop_enable_o(uloop_enable_o),
    .uloop_valid_i(uloop_valid_i), .uloop_done_i(uloop_done_i),
    .stream_start_o(stream_start_o), .stream_done_i(stream_done_i),
    .engine_start_o(engine_start_o), .engine_done_i(engine_done_i),
    .store_start_o(store_start_o), .store_done_i(store_done_i),
    .busy_o(busy_o), .done_o(done_o), .tile_cnt_o(tile_cnt_o), .err_o(err_o)
  );

  typedef struct {
    logic [CW-1:0] tiles;
    logic          err;
  } exp_t;

  typedef struct {
    logic [CW-1:0] cap;
    int            done_at;
    logic [CW-1:0] tiles;
    int            enables;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[6];

  int checks = 0, errors = 0;
  int n_stream = 0, n_engine = 0, n_store = 0, n_enable = 0, n_clear = 0, n_done = 0;
  int s_cnt = 0, c_cnt = 0, t_cnt = 0, upd_n = 0, done_at = 0;
  bit ld_en = 1, cp_en = 1, st_en = 1, ul_due = 0, en_prev = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One cycle: observe outputs at the falling edge, score done_o, then drive the responders.
  task automatic tick();
    bit   en_rise;
    exp_t e;
    @(negedge clk);
    en_rise = uloop_enable_o && !en_prev;
    en_prev = uloop_enable_o;
    if (stream_start_o) n_stream++;
    if (engine_start_o) n_engine++;
    if (store_start_o)  n_store++;
    if (en_rise)        n_enable++;
    if (uloop_clear_o) begin n_clear++; upd_n = 0; end
    if (done_o) begin
      n_done++;
      if (exp_q.size() == 0) check("done_without_job", exp_q.size(), 1);
      else begin
        e = exp_q.pop_front();
        check("sb_tile_cnt", int'(tile_cnt_o), int'(e.tiles));
        check("sb_err", int'(err_o), int'(e.err));
      end
    end
    stream_done_i = 1'b0; engine_done_r = 1'b0; store_done_i = 1'b0;
    uloop_valid_i = 1'b0; uloop_done_i  = 1'b0;
    if (s_cnt != 0) begin s_cnt--; if (s_cnt == 0) stream_done_i = 1'b1; end
    if (c_cnt != 0) begin c_cnt--; if (c_cnt == 0) engine_done_r = 1'b1; end
    if (t_cnt != 0) begin t_cnt--; if (t_cnt == 0) store_done_i  = 1'b1; end
    if (stream_start_o && ld_en) s_cnt = 2;
    if (engine_start_o && cp_en) c_cnt = 2;
    if (store_start_o  && st_en) t_cnt = 2;
    if (ul_due) begin
      upd_n++;
      uloop_valid_i = 1'b1;
      uloop_done_i  = (upd_n == done_at);
      ul_due = 1'b0;
    end
    if (en_rise) ul_due = 1'b1;
  endtask

  task automatic push_exp(input logic [CW-1:0] tiles, input logic err);
    exp_t e;
    e.tiles = tiles;
    e.err   = err;
    exp_q.push_back(e);
  endtask

  task automatic start_job(input logic [CW-1:0] cap, input int d_at);
    done_at       = d_at;
    cfg_n_tiles_i = cap;
    start_i       = 1'b1;
    tick();
    start_i       = 1'b0;
    cfg_n_tiles_i = '1;
  endtask

  task automatic run_job(input string tag, input logic [CW-1:0] cap, input int d_at,
                         input logic [CW-1:0] exp_tiles, input int exp_en);
    int d0, s0, e0, t0, u0, c0, i;
    d0 = n_done; s0 = n_stream; e0 = n_engine; t0 = n_store; u0 = n_enable; c0 = n_clear;
    push_exp(exp_tiles, 1'b0);
    start_job(cap, d_at);
    check({tag, "_clear_pulse"}, int'(uloop_clear_o), 1);
    check({tag, "_stream_pulse"}, int'(stream_start_o), 1);
    check({tag, "_busy_rise"}, int'(busy_o), 1);
    check({tag, "_err_cleared"}, int'(err_o), 0);
    i = 0;
    while (n_done == d0 && i < 600) begin tick(); i++; end
    check({tag, "_done_count"}, n_done - d0, 1);
    tick(); tick();
    check({tag, "_busy_fall"}, int'(busy_o), 0);
    check({tag, "_tile_hold"}, int'(tile_cnt_o), int'(exp_tiles));
    check({tag, "_stream_starts"}, n_stream - s0, int'(exp_tiles));
    check({tag, "_engine_starts"}, n_engine - e0, int'(exp_tiles));
    check({tag, "_store_starts"}, n_store - t0, int'(exp_tiles));
    check({tag, "_enables"}, n_enable - u0, exp_en);
    check({tag, "_clears"}, n_clear - c0, 1);
  endtask

  initial begin
    int d0, c0, t0, e0, i;
    vecs[0] = '{12'd0, 3, 12'd3, 3};
    vecs[1] = '{12'd2, 0, 12'd2, 1};
    vecs[2] = '{12'd1, 0, 12'd1, 0};
    vecs[3] = '{12'd5, 2, 12'd2, 2};
    vecs[4] = '{12'd0, 1, 12'd1, 1};
    vecs[5] = '{12'd3, 3, 12'd3, 2};

    rst_n = 1'b0; clear_i = 1'b0; start_i = 1'b0; cfg_n_tiles_i = '0;
    uloop_valid_i = 1'b0; uloop_done_i = 1'b0; stream_done_i = 1'b0;
    engine_done_r = 1'b0; engine_done_m = 1'b0; store_done_i = 1'b0;
    tick(); tick();
    check("rst_busy", int'(busy_o), 0);
    check("rst_done", int'(done_o), 0);
    check("rst_tile_cnt", int'(tile_cnt_o), 0);
    check("rst_err", int'(err_o), 0);
    check("rst_uloop_clear", int'(uloop_clear_o), 0);
    check("rst_uloop_enable", int'(uloop_enable_o), 0);
    check("rst_starts", int'({stream_start_o, engine_start_o, store_start_o}), 0);
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 6; v++)
      run_job($sformatf("job%0d", v), vecs[v].cap, vecs[v].done_at, vecs[v].tiles, vecs[v].enables);

    // Engine done coinciding with its start pulse must be ignored.
    cp_en = 1'b0;
    d0 = n_done; t0 = n_store;
    push_exp(12'd1, 1'b0);
    start_job(12'd0, 1);
    i = 0;
    while (!engine_start_o && i < 100) begin tick(); i++; end
    check("early_reach_compute", int'(engine_start_o), 1);
    engine_done_m = 1'b1;
    tick();
    engine_done_m = 1'b0;
    tick(); tick(); tick();
    check("early_stays_compute", n_store - t0, 0);
    check("early_busy", int'(busy_o), 1);
    engine_done_m = 1'b1;
    tick();
    engine_done_m = 1'b0;
    check("late_done_to_store", int'(store_start_o), 1);
    cp_en = 1'b1;
    i = 0;
    while (n_done == d0 && i < 200) begin tick(); i++; end
    check("early_job_done", n_done - d0, 1);
    tick(); tick();

    // Ignored start during LOAD, then soft clear during the second tile's STORE.
    d0 = n_done; c0 = n_clear; t0 = n_store;
    start_job(12'd0, 3);
    tick();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check("ignored_start_no_clear", int'(uloop_clear_o), 0);
    i = 0;
    while (n_store - t0 < 2 && i < 300) begin tick(); i++; end
    check("clear_pre_tile_cnt", int'(tile_cnt_o), 1);
    clear_i = 1'b1;
    start_i = 1'b1;
    tick();
    clear_i = 1'b0;
    start_i = 1'b0;
    check("clear_busy", int'(busy_o), 0);
    check("clear_tile_cnt", int'(tile_cnt_o), 0);
    check("clear_store_pulse", int'(store_start_o), 0);
    for (int k = 0; k < 20; k++) tick();
    check("clear_no_done", n_done - d0, 0);
    check("clear_single_uloop_clear", n_clear - c0, 1);

    // Asynchronous reset in the middle of the second tile's COMPUTE.
    e0 = n_engine;
    start_job(12'd0, 3);
    i = 0;
    while (n_engine - e0 < 2 && i < 300) begin tick(); i++; end
    tick();
    check("rst_mid_pre_cnt", int'(tile_cnt_o), 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", int'(busy_o), 0);
    check("rst_mid_tile_cnt", int'(tile_cnt_o), 0);
    check("rst_mid_pulses", int'({uloop_enable_o, stream_start_o, engine_start_o, store_start_o, done_o}), 0);
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    run_job("after_rst", 12'd0, 2, 12'd2, 2);

    // Withheld load-stream done.
    ld_en = 1'b0;
    d0 = n_done; e0 = n_engine;
`ifdef HWPE_CTRL_SEQ_TIMEOUT_EN
    push_exp(12'd0, 1'b1);
    start_job(12'd0, 0);
    i = 1;
    while (n_done == d0 && i < 100) begin tick(); i++; end
    check("timeout_done", n_done - d0, 1);
    check("timeout_latency", i, TO + 1);
    tick();
    check("timeout_err_sticky", int'(err_o), 1);
    check("timeout_busy_fall", int'(busy_o), 0);
`else
    start_job(12'd0, 0);
    for (int k = 0; k < 40; k++) tick();
    check("no_wd_err", int'(err_o), 0);
    check("no_wd_busy", int'(busy_o), 1);
    check("no_wd_stuck_load", n_engine - e0, 0);
    check("no_wd_no_done", n_done - d0, 0);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check("no_wd_clear_exit", int'(busy_o), 0);
`endif
    ld_en = 1'b1;
    tick();
    run_job("post_wd", 12'd2, 0, 12'd2, 1);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hwpe_ctrl_seq_fsm.md
Name: hwpe_ctrl_seq_fsm

Overview:
- Main tile-sequencing controller of an HWPE.
- Sits between the slave control block and the datapath:
  - On slave start: clears the micro-loop unit.
  - Per tile, runs load → compute → store, then advances the micro-loop.
  - Stops when the micro-loop reports done or a configured tile cap is reached.
- Returns a single done pulse to the slave, which raises the completion event.

Parameters:
- CNT_WIDTH, 12, width of tile counter and tile cap (matches micro-loop counter width)
- TIMEOUT_CYCLES, 1024, per-wait-state watchdog limit (used only with the optional feature)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- clear_i  in  1  synchronous soft clear (slave softclear), highest priority
- start_i  in  1  job start pulse from slave
- cfg_n_tiles_i  in  CNT_WIDTH  tile cap; 0 = unlimited; sampled on accepted start
- uloop_clear_o  out  1  micro-loop clear pulse
- uloop_enable_o  out  1  micro-loop advance request
- uloop_valid_i  in  1  micro-loop result valid (new offsets/indices)
- uloop_done_i  in  1  micro-loop finished; qualified by uloop_valid_i
- stream_start_o  out  1  load-stream start pulse
- stream_done_i  in  1  load-stream complete
- engine_start_o  out  1  engine compute start pulse
- engine_done_i  in  1  engine compute complete
- store_start_o  out  1  store-stream start pulse
- store_done_i  in  1  store-stream complete
- busy_o  out  1  job in progress (slave is_working)
- done_o  out  1  job complete pulse to slave
- tile_cnt_o  out  CNT_WIDTH  completed tiles in current job
- err_o  out  1  watchdog error flag (optional feature)

Behaviour:
- Reset (rst_ni=0, async):
  - state IDLE.
  - All outputs 0: tile_cnt_o=0, err_o=0, busy_o=0.
  - Registered tile cap = 0.
- All outputs are registered.
- States: IDLE, LOAD, COMPUTE, STORE, UPDATE, FINISHED.
- IDLE:
  - start_i=1 → uloop_clear_o=1 for exactly the next cycle, tile_cnt←0, cap←cfg_n_tiles_i, go LOAD.
  - start_i at cycle N gives uloop_clear_o, stream_start_o and busy_o all high at cycle N+1.
- start_i outside IDLE is ignored; no queuing.
- LOAD, COMPUTE, STORE:
  - The matching *_start_o is high only in the first cycle of the state.
  - The matching *_done_i is accepted only from the following cycle onward; a done in the pulse cycle is ignored.
  - On accepted done: LOAD→COMPUTE, COMPUTE→STORE, STORE→UPDATE.
- UPDATE:
  - On entry, tile_cnt increments by 1 (wraps at 2^CNT_WIDTH; wrap reachable only with cap=0).
  - If cap≠0 and new tile_cnt==cap: go FINISHED; uloop_enable_o is never asserted.
  - Otherwise uloop_enable_o is held high until uloop_valid_i=1 is sampled, and drops the cycle after.
    - valid with uloop_done_i=1 → FINISHED.
    - valid with uloop_done_i=0 → LOAD.
- FINISHED:
  - done_o=1 for exactly one cycle, then IDLE.
  - busy_o falls in the cycle after done_o.
  - tile_cnt_o holds its final value until the next accepted start.
- busy_o=1 in every state except IDLE.
- clear_i=1 in any state:
  - Next state IDLE; all pulses and uloop_enable_o deassert next cycle.
  - tile_cnt←0, err_o←0, no done_o.
  - clear_i beats a simultaneous start_i.
- Unexpected *_done_i in a non-matching state is ignored.
- Unqualified uloop_done_i (without uloop_valid_i) is ignored.

Optional Feature:
- Macro: HWPE_CTRL_SEQ_TIMEOUT_EN
- Defined:
  - A watchdog counter resets on every state entry and counts cycles spent in LOAD, COMPUTE, STORE and UPDATE.
  - When it reaches TIMEOUT_CYCLES without the awaited done/valid: err_o←1 (sticky), go FINISHED, done_o pulses normally.
  - err_o clears on the next accepted start_i or on clear_i.
- Undefined: no watchdog logic; err_o tied to 0; FSM waits indefinitely.

Test Plan:
- Reset mid-job: assert rst_ni=0 during COMPUTE → all outputs 0 immediately; after release, start_i → normal job from tile 0.
- 3-tile job, cap=0: start_i; each done returned 2 cycles after its start pulse; uloop_valid_i one cycle after uloop_enable_o, uloop_done_i=1 on 3rd update → exactly 3 each of stream/engine/store start pulses, tile_cnt_o=3, one done_o, 2 uloop_enable_o assertions that produce valid without done.
- Tile cap: cap=2 with micro-loop never reporting done → done_o after 2nd STORE, tile_cnt_o=2, uloop_enable_o asserted exactly once.
- Early done: engine_done_i high in the same cycle as engine_start_o and low afterwards → FSM stays in COMPUTE; a later engine_done_i pulse advances to STORE.
- Clear and ignored start: clear_i during STORE of tile 1 → IDLE next cycle, busy_o=0, tile_cnt_o=0, no done_o. Separately, start_i during LOAD → ignored, no second uloop_clear_o.
- Timeout (macro defined, TIMEOUT_CYCLES=16): withhold stream_done_i → after 16 cycles in LOAD, err_o=1 and done_o pulses once. Next start_i clears err_o. Without macro, err_o stays 0 and the FSM stays in LOAD.
